regfile_read_stage: RTL and testbench

Register-file read stage for the pipelined LEGv8 CPU: thirty-one 64-bit architectural registers plus hard-wired XZR, one write port driven by writeback and two read ports whose results are captured into the ID/EX operand latches. It is the read-side counterpart of the enabled 64-bit storage element used for pipeline state. It resolves same-cycle write/read hazards and keeps stalled operands coherent with late writebacks, so the decode stage needs no external forwarding for register-file values.

---
 rtl/regfile_read_stage_pkg.sv | 6 +
 rtl/regfile_read_stage_array.sv | 33 +++
 rtl/regfile_read_stage.sv | 61 ++++++
 tb/tb_regfile_read_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/regfile_read_stage_pkg.sv
// regfile_read_stage_pkg: shared register-address constants and types for the LEGv8 pipeline
package regfile_read_stage_pkg;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] XZR = 5'd31;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_read_stage_array.sv
// regfile_array: 31 stored registers plus XZR, one write port, two bypassed combinational read ports
module regfile_array
  import regfile_read_stage_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b
);
  logic [WIDTH-1:0] mem_q [NREGS-1];
  logic [WIDTH-1:0] mem_d [NREGS-1];
  logic             wr_hit;
  always_comb begin
    wr_hit = wr_en && wr_addr != XZR;
    for (int i = 0; i < NREGS - 1; i++)
      mem_d[i] = (wr_hit && wr_addr == ADDR_W'(i)) ? wr_data : mem_q[i];
    rd_data_a = rd_addr_a == XZR ? '0 : (wr_en && wr_addr == rd_addr_a) ? wr_data : mem_q[rd_addr_a];
    rd_data_b = rd_addr_b == XZR ? '0 : (wr_en && wr_addr == rd_addr_b) ? wr_data : mem_q[rd_addr_b];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < NREGS - 1; i++) mem_q[i] <= '0;
    else
      mem_q <= mem_d;
endmodule

// File: rtl/regfile_read_stage.sv
// regfile_read_stage: register-file read with ID/EX operand latches, stall refresh and flush
module regfile_read_stage
  import regfile_read_stage_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              stall,
  input  logic              flush,
  output logic [WIDTH-1:0]  op_a,
  output logic [WIDTH-1:0]  op_b,
  output logic              op_valid
);
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             op_valid_q, op_valid_d, wr_hit;
  reg_addr_t        cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  regfile_array #(.WIDTH(WIDTH), .NREGS(NREGS)) u_array (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_a),
    .rd_data_b (rd_b)
  );
  always_comb begin
    wr_hit     = wr_en && wr_addr != XZR;
    op_a_d     = flush ? '0 : !stall ? rd_a : (wr_hit && cap_a_q == wr_addr) ? wr_data : op_a_q;
    op_b_d     = flush ? '0 : !stall ? rd_b : (wr_hit && cap_b_q == wr_addr) ? wr_data : op_b_q;
    op_valid_d = flush ? 1'b0 : stall ? op_valid_q : 1'b1;
    cap_a_d    = flush ? XZR : stall ? cap_a_q : rd_addr_a;
    cap_b_d    = flush ? XZR : stall ? cap_b_q : rd_addr_b;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      cap_a_q    <= XZR;
      cap_b_q    <= XZR;
    end else begin
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      cap_a_q    <= cap_a_d;
      cap_b_q    <= cap_b_d;
    end
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_valid = op_valid_q;
endmodule

// File: tb/tb_regfile_read_stage.sv
// tb_regfile_read_stage: scoreboard bench for regfile_read_stage
module tb_regfile_read_stage;
  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        v;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [63:0] wr_data = '0;
  logic [4:0]  rd_addr_a = 5'd0;
  logic [4:0]  rd_addr_b = 5'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] op_a, op_b;
  logic        op_valid;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [63:0] m_mem [32];
  logic [63:0] m_a, m_b;
  logic        m_v;
  logic [4:0]  m_ca, m_cb;
  regfile_read_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .stall     (stall),
    .flush     (flush),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] m_rd(input logic [4:0] a);
    if (a == 5'd31) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_a = '0; m_b = '0; m_v = 1'b0; m_ca = 5'd31; m_cb = 5'd31;
  endtask
  task automatic cycle(input string tag, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic st, input logic fl);
    exp_t e;
    logic [63:0] va, vb;
    logic        hit;
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb; stall = st; flush = fl;
    va  = m_rd(ra);
    vb  = m_rd(rb);
    hit = we && wa != 5'd31;
    if (fl) begin
      m_a = '0; m_b = '0; m_v = 1'b0; m_ca = 5'd31; m_cb = 5'd31;
    end else if (st) begin
      if (hit && m_ca == wa) m_a = wd;
      if (hit && m_cb == wa) m_b = wd;
    end else begin
      m_a = va; m_b = vb; m_v = 1'b1; m_ca = ra; m_cb = rb;
    end
    if (hit) m_mem[wa] = wd;
    sb.push_back('{a: m_a, b: m_b, v: m_v});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".op_a"}, op_a, e.a);
      check({tag, ".op_b"}, op_b, e.b);
      check({tag, ".op_valid"}, {63'd0, op_valid}, {63'd0, e.v});
    end
  endtask
  initial begin
    m_reset();
    #12;
    check("reset.op_a", op_a, 64'd0);
    check("reset.op_b", op_b, 64'd0);
    check("reset.op_valid", {63'd0, op_valid}, 64'd0);
    reset_n = 1'b1;
    cycle("rd_x0_x5", 1'b0, 5'd0, 64'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    cycle("wr_x3", 1'b1, 5'd3, 64'h1111_2222_3333_4444, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle("rd_x3", 1'b0, 5'd0, 64'd0, 5'd3, 5'd0, 1'b0, 1'b0);
    check("rd_x3.direct", op_a, 64'h1111_2222_3333_4444);
    cycle("bypass_x7", 1'b1, 5'd7, 64'hDEAD, 5'd7, 5'd7, 1'b0, 1'b0);
    check("bypass_x7.direct", op_b, 64'hDEAD);
    cycle("wr_x31", 1'b1, 5'd31, 64'hFFFF, 5'd3, 5'd31, 1'b0, 1'b0);
    cycle("rd_x31", 1'b0, 5'd0, 64'd0, 5'd7, 5'd31, 1'b0, 1'b0);
    check("rd_x31.direct", op_b, 64'd0);
    cycle("wr_x9", 1'b1, 5'd9, 64'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle("wr_x10", 1'b1, 5'd10, 64'h10, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle("latch_x9", 1'b0, 5'd0, 64'd0, 5'd9, 5'd10, 1'b0, 1'b0);
    cycle("stall1", 1'b1, 5'd31, 64'hFFFF, 5'd1, 5'd2, 1'b1, 1'b0);
    check("stall1.direct", op_a, 64'd5);
    cycle("stall2", 1'b1, 5'd9, 64'h42, 5'd1, 5'd2, 1'b1, 1'b0);
    check("stall2.direct_a", op_a, 64'h42);
    check("stall2.direct_b", op_b, 64'h10);
    cycle("stall3", 1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 1'b1, 1'b0);
    cycle("flush_wr_x4", 1'b1, 5'd4, 64'h99, 5'd9, 5'd10, 1'b1, 1'b1);
    check("flush.direct", {63'd0, op_valid}, 64'd0);
    cycle("stall_after_flush", 1'b1, 5'd4, 64'h77, 5'd4, 5'd4, 1'b1, 1'b0);
    cycle("rd_x4", 1'b0, 5'd0, 64'd0, 5'd4, 5'd9, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      logic [4:0] pool [8];
      pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 5'd29, 5'd30, 5'd31};
      cycle("random", 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], {$urandom, $urandom},
            pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end
    cycle("pre_reset", 1'b1, 5'd3, 64'hABCD, 5'd3, 5'd9, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    check("async_reset.op_a", op_a, 64'd0);
    check("async_reset.op_valid", {63'd0, op_valid}, 64'd0);
    #1;
    reset_n = 1'b1;
    cycle("post_reset", 1'b0, 5'd0, 64'd0, 5'd3, 5'd9, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
